// File: rtl/alarm_ring.sv
// alarm_ring: compares the latched alarm minutes against the running minutes
// at each minute rollover and runs the IDLE/RING/SNOOZE ringing machine.
// Drives a square-wave buzzer tone while ringing.
// Optional snooze cycle is built only when ALARM_SNOOZE_EN is defined;
// without it the snooze input is ignored and snooze_active is tied low.
module alarm_ring #(
    parameter int unsigned RING_SEC   = 30,     // 1..255 seconds of ringing
    parameter int unsigned SNOOZE_MIN = 5,      // 1..255 minute rollovers
    parameter int unsigned TONE_DIV   = 50000   // clocks per buzzer half-period
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sec_tick,
    input  logic       min_roll,
    input  logic [3:0] cur_min1,
    input  logic [3:0] cur_min2,
    input  logic [3:0] clock_min1,
    input  logic [3:0] clock_min2,
    input  logic       alarm_en,
    input  logic       stop,
    input  logic       snooze,
    output logic       ringing,
    output logic       buzzer,
    output logic       snooze_active
);

    localparam logic [7:0]  RING_LAST   = 8'(RING_SEC - 1);
    localparam logic [7:0]  SNOOZE_LAST = 8'(SNOOZE_MIN - 1);
    localparam logic [23:0] TONE_LAST   = 24'(TONE_DIV - 1);

`ifdef ALARM_SNOOZE_EN
    typedef enum logic [1:0] {IDLE = 2'd0, RING = 2'd1, SNOOZE = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, RING = 2'd1} state_t;
`endif

    state_t      state_q;
    logic [7:0]  ring_sec_q;
    logic [23:0] tone_cnt_q;
    logic        ringing_q;
    logic        buzzer_q;
`ifdef ALARM_SNOOZE_EN
    logic [7:0]  snooze_min_q;
    logic        snooze_active_q;
`endif

    // Raw 4-bit compare, only meaningful in the rollover cycle.
    logic match;
    assign match = min_roll && (cur_min1 == clock_min1) && (cur_min2 == clock_min2);

    logic tone_wrap;
    assign tone_wrap = (tone_cnt_q == TONE_LAST);

    // Ringing state machine; outputs are registered alongside the state so
    // they follow the state one clock after the cause.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ring_sec_q <= '0;
            tone_cnt_q <= '0;
            ringing_q  <= 1'b0;
            buzzer_q   <= 1'b0;
`ifdef ALARM_SNOOZE_EN
            snooze_min_q    <= '0;
            snooze_active_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    // A match blocked by stop is simply lost, not retried.
                    if (alarm_en && match && !stop) begin
                        state_q    <= RING;
                        ringing_q  <= 1'b1;
                        ring_sec_q <= '0;
                        tone_cnt_q <= '0;
                        buzzer_q   <= 1'b0;
                    end
                end
                RING: begin
                    if (!alarm_en || stop) begin
                        state_q    <= IDLE;
                        ringing_q  <= 1'b0;
                        buzzer_q   <= 1'b0;
                        tone_cnt_q <= '0;
                    end
`ifdef ALARM_SNOOZE_EN
                    else if (snooze) begin
                        state_q         <= SNOOZE;
                        ringing_q       <= 1'b0;
                        buzzer_q        <= 1'b0;
                        tone_cnt_q      <= '0;
                        snooze_min_q    <= '0;
                        snooze_active_q <= 1'b1;
                    end
`endif
                    else if (sec_tick && ring_sec_q == RING_LAST) begin
                        state_q    <= IDLE;
                        ringing_q  <= 1'b0;
                        buzzer_q   <= 1'b0;
                        tone_cnt_q <= '0;
                    end else begin
                        // min_roll (even a re-match) has no effect here.
                        if (sec_tick) begin
                            ring_sec_q <= ring_sec_q + 8'd1;
                        end
                        if (tone_wrap) begin
                            tone_cnt_q <= '0;
                            buzzer_q   <= ~buzzer_q;
                        end else begin
                            tone_cnt_q <= tone_cnt_q + 24'd1;
                        end
                    end
                end
`ifdef ALARM_SNOOZE_EN
                SNOOZE: begin
                    // sec_tick and further snooze requests are ignored here.
                    if (!alarm_en || stop) begin
                        state_q         <= IDLE;
                        snooze_active_q <= 1'b0;
                    end else if (min_roll) begin
                        if (snooze_min_q == SNOOZE_LAST) begin
                            state_q         <= RING;
                            snooze_active_q <= 1'b0;
                            ringing_q       <= 1'b1;
                            ring_sec_q      <= '0;
                            tone_cnt_q      <= '0;
                            buzzer_q        <= 1'b0;
                        end else begin
                            snooze_min_q <= snooze_min_q + 8'd1;
                        end
                    end
                end
`endif
                default: begin
                    state_q    <= IDLE;
                    ringing_q  <= 1'b0;
                    buzzer_q   <= 1'b0;
                    tone_cnt_q <= '0;
`ifdef ALARM_SNOOZE_EN
                    snooze_active_q <= 1'b0;
`endif
                end
            endcase
        end
    end

    assign ringing = ringing_q;
    assign buzzer  = buzzer_q;

`ifdef ALARM_SNOOZE_EN
    assign snooze_active = snooze_active_q;
`else
    assign snooze_active = 1'b0;
    // Snooze request and length have no consumer in this build.
    logic unused_snooze;
    assign unused_snooze = ^{snooze, SNOOZE_LAST};
`endif

endmodule

// File: tb/tb_alarm_ring.sv
// tb_alarm_ring: directed stimulus for alarm_ring with a behavioural
// reference model compared every clock, plus literal pins at key points.
module tb_alarm_ring;

    localparam int RING_SEC   = 3;
    localparam int SNOOZE_MIN = 2;
    localparam int TONE_DIV   = 4;
`ifdef ALARM_SNOOZE_EN
    localparam bit SNZ = 1'b1;
`else
    localparam bit SNZ = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sec_tick = 1'b0, min_roll = 1'b0;
    logic [3:0] cur_min1 = 4'd0, cur_min2 = 4'd0;
    logic [3:0] clock_min1 = 4'd0, clock_min2 = 4'd0;
    logic       alarm_en = 1'b0, stop = 1'b0, snooze = 1'b0;
    logic       ringing, buzzer, snooze_active;

    int checks = 0;
    int errors = 0;

    alarm_ring #(
        .RING_SEC  (RING_SEC),
        .SNOOZE_MIN(SNOOZE_MIN),
        .TONE_DIV  (TONE_DIV)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sec_tick     (sec_tick),
        .min_roll     (min_roll),
        .cur_min1     (cur_min1),
        .cur_min2     (cur_min2),
        .clock_min1   (clock_min1),
        .clock_min2   (clock_min2),
        .alarm_en     (alarm_en),
        .stop         (stop),
        .snooze       (snooze),
        .ringing      (ringing),
        .buzzer       (buzzer),
        .snooze_active(snooze_active)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 idle, 1 ringing, 2 snoozing.
    // Buzzer is derived from clocks spent ringing: high in odd TONE_DIV windows.
    int   m_mode = 0;
    int   m_ring_clks = 0;
    int   m_ticks = 0;
    int   m_rolls = 0;
    logic m_hit;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_ring_clks = 0; m_ticks = 0; m_rolls = 0;
        end else begin
            m_hit = min_roll && cur_min1 == clock_min1 && cur_min2 == clock_min2;
            case (m_mode)
                0: if (alarm_en && m_hit && !stop) begin
                    m_mode = 1; m_ring_clks = 0; m_ticks = 0;
                end
                1: if (!alarm_en || stop) m_mode = 0;
                   else if (SNZ && snooze) begin m_mode = 2; m_rolls = 0; end
                   else begin
                       if (sec_tick) m_ticks++;
                       if (m_ticks == RING_SEC) m_mode = 0;
                       else m_ring_clks++;
                   end
                default: if (!alarm_en || stop) m_mode = 0;
                   else if (min_roll) begin
                       m_rolls++;
                       if (m_rolls == SNOOZE_MIN) begin
                           m_mode = 1; m_ring_clks = 0; m_ticks = 0;
                       end
                   end
            endcase
        end
    end

    logic e_ring, e_buz, e_snz;
    assign e_ring = (m_mode == 1);
    assign e_buz  = (m_mode == 1) && (((m_ring_clks / TONE_DIV) % 2) == 1);
    assign e_snz  = (m_mode == 2);

    task automatic chk(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0b want %0b", nm, act, exp);
        end
    endtask

    // Pin both the DUT and the model to a hand-derived value.
    task automatic pin(input string nm, input logic d, input logic m, input logic lit);
        chk({nm, "_dut"}, d, lit);
        chk({nm, "_model"}, m, lit);
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("cyc_ringing", ringing, e_ring);
            chk("cyc_buzzer", buzzer, e_buz);
            chk("cyc_snooze_active", snooze_active, e_snz);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic roll(input logic [3:0] a, input logic [3:0] b);
        cur_min1 = a; cur_min2 = b; min_roll = 1'b1;
        @(negedge clk);
        min_roll = 1'b0;
    endtask

    task automatic tick();
        sec_tick = 1'b1;
        @(negedge clk);
        sec_tick = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    task automatic pulse_snooze();
        snooze = 1'b1;
        @(negedge clk);
        snooze = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #1;
        chk("rst_ringing", ringing, 1'b0);
        chk("rst_buzzer", buzzer, 1'b0);
        chk("rst_snooze_active", snooze_active, 1'b0);
        cyc(2);
        rst_n = 1'b1;
        cyc(1);

        // Match at 3/0 and tone/timeout behaviour
        clock_min1 = 4'd3; clock_min2 = 4'd0; alarm_en = 1'b1;
        roll(4'd2, 4'd9);  pin("nomatch_29", ringing, e_ring, 1'b0);
        roll(4'd3, 4'd0);  pin("match_ring", ringing, e_ring, 1'b1);
        pin("match_buz0", buzzer, e_buz, 1'b0);
        cyc(3);            pin("buz_pre_rise", buzzer, e_buz, 1'b0);
        cyc(1);            pin("buz_rise", buzzer, e_buz, 1'b1);
        cyc(4);            pin("buz_fall", buzzer, e_buz, 1'b0);
        tick(); tick();    pin("ring_after_2ticks", ringing, e_ring, 1'b1);
        tick();            pin("timeout_ring", ringing, e_ring, 1'b0);
        pin("timeout_buz", buzzer, e_buz, 1'b0);

        // No match / disarmed
        roll(4'd3, 4'd1);  pin("nomatch_31", ringing, e_ring, 1'b0);
        alarm_en = 1'b0;
        roll(4'd3, 4'd0);  pin("disarmed", ringing, e_ring, 1'b0);
        alarm_en = 1'b1;
        cyc(1);

        // Stop in RING, later non-matching rollover
        roll(4'd3, 4'd0);  pin("ring_for_stop", ringing, e_ring, 1'b1);
        cyc(2);
        pulse_stop();      pin("stop_idle", ringing, e_ring, 1'b0);
        roll(4'd3, 4'd1);  pin("after_stop_31", ringing, e_ring, 1'b0);

        // Stop held in IDLE blocks the match, no retry
        stop = 1'b1;
        roll(4'd3, 4'd0);
        stop = 1'b0;       pin("stop_blocks", ringing, e_ring, 1'b0);
        cyc(2);            pin("no_retry", ringing, e_ring, 1'b0);

        // Stop and snooze together in RING
        roll(4'd3, 4'd0);
        stop = 1'b1; snooze = 1'b1;
        cyc(1);
        stop = 1'b0; snooze = 1'b0;
        pin("stop_snooze_ring", ringing, e_ring, 1'b0);
        pin("stop_snooze_snz", snooze_active, e_snz, 1'b0);

        // Disarm during RING
        roll(4'd3, 4'd0);
        cyc(1);
        alarm_en = 1'b0;
        cyc(1);
        alarm_en = 1'b1;   pin("disarm_ring", ringing, e_ring, 1'b0);

        // sec_tick together with a matching min_roll while ringing
        roll(4'd3, 4'd0);
        sec_tick = 1'b1;
        roll(4'd3, 4'd0);
        sec_tick = 1'b0;   pin("tick_roll_ring", ringing, e_ring, 1'b1);
        tick();            pin("tick_roll_2", ringing, e_ring, 1'b1);
        tick();            pin("tick_roll_timeout", ringing, e_ring, 1'b0);

`ifdef ALARM_SNOOZE_EN
        // Snooze cycle, re-ring with fresh seconds count, stop in SNOOZE
        roll(4'd3, 4'd0);
        tick();
        cyc(4);
        pulse_snooze();
        pin("snz_active", snooze_active, e_snz, 1'b1);
        pin("snz_ring0", ringing, e_ring, 1'b0);
        pin("snz_buz0", buzzer, e_buz, 1'b0);
        tick(); pulse_snooze();
        pin("snz_ignores", snooze_active, e_snz, 1'b1);
        roll(4'd1, 4'd2);  pin("snz_roll1", snooze_active, e_snz, 1'b1);
        roll(4'd1, 4'd3);  pin("snz_reri ng", ringing, e_ring, 1'b1);
        pin("snz_reri_snz0", snooze_active, e_snz, 1'b0);
        tick(); tick();    pin("snz_fresh_sec", ringing, e_ring, 1'b1);
        pulse_snooze();    pin("snz_again", snooze_active, e_snz, 1'b1);
        pulse_stop();
        pin("snz_stop_snz", snooze_active, e_snz, 1'b0);
        pin("snz_stop_ring", ringing, e_ring, 1'b0);
`else
        // Snooze request is ignored in this build
        roll(4'd3, 4'd0);
        cyc(1);
        snooze = 1'b1;
        cyc(2);
        snooze = 1'b0;
        pin("nosnz_ring", ringing, e_ring, 1'b1);
        pin("nosnz_active", snooze_active, e_snz, 1'b0);
        pulse_stop();      pin("nosnz_stop", ringing, e_ring, 1'b0);
`endif

        // Asynchronous reset while buzzer is high
        roll(4'd3, 4'd0);
        cyc(4);            pin("pre_rst_buz", buzzer, e_buz, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_ringing", ringing, 1'b0);
        chk("async_rst_buzzer", buzzer, 1'b0);
        chk("async_rst_snz", snooze_active, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(2);            pin("post_rst_idle", ringing, e_ring, 1'b0);
        roll(4'd3, 4'd0);  pin("post_rst_match", ringing, e_ring, 1'b1);
        pulse_stop();      pin("post_rst_stop", ringing, e_ring, 1'b0);
        cyc(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alarm_ring.md
Name: alarm_ring

Overview:
- Downstream of the alarm-minute setter; consumes the latched alarm digits `clock_min1` (tens) and `clock_min2` (ones).
- Compares them against the running time-of-day minutes at each minute rollover and drives a ringing state machine.
- Outputs a square-wave buzzer tone, a ringing indicator and an optional snooze cycle.
- Sits between the alarm setter, the time counter and the buzzer pin.

Parameters:
- RING_SEC, 30, maximum ringing duration in seconds before auto-stop; legal range 1..255.
- SNOOZE_MIN, 5, snooze length in minute rollovers; legal range 1..255.
- TONE_DIV, 50000, clocks per buzzer half-period; legal range 1..2^24-1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- sec_tick  in  1  one-cycle pulse once per second.
- min_roll  in  1  one-cycle pulse when seconds wrap 59->00; cur_min digits are already updated in that cycle.
- cur_min1  in  4  current minutes tens digit (BCD).
- cur_min2  in  4  current minutes ones digit (BCD).
- clock_min1  in  4  alarm minutes tens digit (BCD).
- clock_min2  in  4  alarm minutes ones digit (BCD).
- alarm_en  in  1  alarm armed (level).
- stop  in  1  stop request (level, sampled each clk; pre-debounced).
- snooze  in  1  snooze request (level, sampled each clk; pre-debounced).
- ringing  out  1  high in RING.
- buzzer  out  1  tone output; 0 outside RING.
- snooze_active  out  1  high in SNOOZE.

Behaviour:
- Clock and reset: single clock domain `clk`; reset `rst_n` is asynchronous and active-low.
- Reset: state=IDLE; all outputs 0; ring_sec, snooze_min and tone_cnt cleared to 0.
- Match: `match = min_roll & (cur_min1==clock_min1) & (cur_min2==clock_min2)`.
  - Raw 4-bit equality; no BCD validity check.
  - Alarm digits are sampled only in the match cycle; changes during RING or SNOOZE have no effect.
- States: IDLE, RING, SNOOZE. All outputs are registered from state, so the entry cycle is visible one clk after the cause.
- IDLE:
  - `alarm_en & match & ~stop` -> RING; clear ring_sec and tone_cnt.
- RING, transition priority (highest first):
  - `~alarm_en` or `stop` -> IDLE.
  - `snooze` -> SNOOZE; clear snooze_min.
  - `sec_tick & ring_sec==RING_SEC-1` -> IDLE (timeout).
  - Otherwise, each sec_tick increments ring_sec.
  - min_roll is ignored in RING, including a re-match.
- RING tone:
  - tone_cnt counts 0..TONE_DIV-1; buzzer toggles on wrap.
  - First buzzer rise occurs TONE_DIV clks after entering RING.
  - On leaving RING, buzzer is forced to 0 and tone_cnt cleared in the same cycle as the state change.
- SNOOZE, transition priority (highest first):
  - `~alarm_en` or `stop` -> IDLE.
  - `min_roll & snooze_min==SNOOZE_MIN-1` -> RING; clear ring_sec and tone_cnt.
  - Otherwise, each min_roll increments snooze_min.
  - sec_tick and snooze are ignored in SNOOZE.
- Simultaneous events:
  - sec_tick and min_roll in the same RING cycle: the sec_tick is counted normally.
  - stop held high in IDLE blocks a match; the missed match is not retried.
- Repeated snoozes are unlimited.
- Reset asserted mid-RING: buzzer drops to 0 immediately (asynchronous).

Optional Feature:
- Macro: ALARM_SNOOZE_EN.
- Defined: SNOOZE state and snooze_min counter exist as specified above.
- Undefined:
  - snooze input is ignored and the SNOOZE state is not built.
  - snooze_active is tied to 0.
  - RING exits only by stop, ~alarm_en or timeout.

Test Plan:
Benches use RING_SEC=3, SNOOZE_MIN=2, TONE_DIV=4.
- Match: alarm=3/0, alarm_en=1, cur_min 2/9 -> 3/0 with min_roll -> ringing=1 next clk; buzzer toggles every 4 clk; after 3 sec_ticks ringing=0 and buzzer=0.
- No match or disarmed:
  - alarm=3/0, cur_min 3/1 with min_roll -> stays IDLE.
  - alarm_en=0 with a matching min_roll -> stays IDLE.
- Stop: in RING, assert stop for 1 clk -> IDLE next clk; a later min_roll at 3/1 gives no ring.
- Snooze (macro on): in RING, pulse snooze -> snooze_active=1, buzzer=0; first min_roll -> still SNOOZE; second min_roll -> RING with ring_sec=0; pulse stop -> IDLE.
- Priority: stop and snooze asserted in the same RING cycle -> IDLE; stop during SNOOZE -> IDLE.
- Reset: drop rst_n while buzzer=1 in RING -> all outputs 0 with no clk edge; release -> IDLE.
- Macro off: pulse snooze in RING -> remains RING; snooze_active stays 0 throughout.
